// File: rtl/writeback_arbiter_pkg.sv
// Purpose : shared types for the writeback arbiter (physical register id, data word,
//           buffered result entry) plus a small round-robin helper.
// Latency : n/a (types only).
// Backpressure: n/a.
package writeback_arbiter_pkg;

   localparam int P_REG_W = 6;
   localparam int WORD_W  = 32;

   typedef logic [P_REG_W-1:0] p_reg;
   typedef logic [WORD_W-1:0]  word;

   // The register file has exactly two write ports.
   localparam int WB_NUM_WPORTS = 2;

   typedef struct packed {
      p_reg addr;
      word  data;
   } wb_entry_t;

   // Source index following idx in a ring of n sources.
   function automatic int wb_next_src(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Purpose : synchronous FIFO of wb_entry_t, one per result source.
// Latency : push at edge k is visible at head_o after edge k (1 cycle).
// Backpressure: push ignored when full, pop ignored when empty; full_o/empty_o are
//           purely registered so callers can derive ready without a comb loop.
// Ports   : clk_i, rst_i (async, active-high), push_i/push_dat_i, pop_i,
//           head_o (entry at read pointer), empty_o, full_o.
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  wb_entry_t push_dat_i,
   input  logic      pop_i,
   output wb_entry_t head_o,
   output logic      empty_o,
   output logic      full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   wb_entry_t     mem_q [0:DEPTH-1];
   logic          do_push;
   logic          do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   assign wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

   assign head_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: contents are only observed through valid pointers.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Purpose : buffers results from NUM_SRC execute units and drives the register
//           file's two write ports, round-robin, up to two writes per cycle.
// Latency : handshake at edge k -> o_w_en visible after edge k+1 (2 cycles) when uncontended.
// Backpressure: o_ready[s] = source FIFO not full (registered occupancy only), low in reset.
// Ports   : i_clk, i_rst (async, active-high); per source i_valid/o_ready/i_addr/i_data;
//           write ports o_w_en/o_w_addr/o_w_data (registered); o_idle.
// Option  : WB_COLLISION_CHK_EN -- withhold port 1 when its candidate targets the same
//           register as port 0 in the same cycle.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_WPORTS = WB_NUM_WPORTS
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_valid  [0:NUM_SRC-1],
   output logic o_ready  [0:NUM_SRC-1],
   input  p_reg i_addr   [0:NUM_SRC-1],
   input  word  i_data   [0:NUM_SRC-1],
   output logic o_w_en   [0:NUM_WPORTS-1],
   output p_reg o_w_addr [0:NUM_WPORTS-1],
   output word  o_w_data [0:NUM_WPORTS-1],
   output logic o_idle
);

   localparam int SW = $clog2(NUM_SRC);

   logic      fifo_push  [0:NUM_SRC-1];
   logic      fifo_pop   [0:NUM_SRC-1];
   logic      fifo_empty [0:NUM_SRC-1];
   logic      fifo_full  [0:NUM_SRC-1];
   wb_entry_t fifo_head  [0:NUM_SRC-1];

   logic [SW-1:0] rr_ptr_q, rr_ptr_d;
   logic          g0_vld, g1_vld;
   logic [SW-1:0] g0_idx, g1_idx;
   logic          cand_vld;
   logic [SW-1:0] cand_idx;
   int            scan_src;

   logic w_en_q   [0:NUM_WPORTS-1];
   p_reg w_addr_q [0:NUM_WPORTS-1];
   word  w_data_q [0:NUM_WPORTS-1];

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      wb_entry_t push_dat;

      assign o_ready[s]   = !fifo_full[s] && !i_rst;
      // Register 0 is hardwired zero: accept the handshake but drop the entry.
      assign fifo_push[s] = i_valid[s] && o_ready[s] && (i_addr[s] != '0);
      assign fifo_pop[s]  = (g0_vld && (g0_idx == SW'(s))) ||
                            (g1_vld && (g1_idx == SW'(s)));
      assign push_dat     = '{addr: i_addr[s], data: i_data[s]};

      wb_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i      (i_clk),
         .rst_i      (i_rst),
         .push_i     (fifo_push[s]),
         .push_dat_i (push_dat),
         .pop_i      (fifo_pop[s]),
         .head_o     (fifo_head[s]),
         .empty_o    (fifo_empty[s]),
         .full_o     (fifo_full[s])
      );
   end

   // Scan from rr_ptr: first non-empty source takes port 0, the next one is the
   // port-1 candidate. Distinct sources by construction, so one pop per source.
   always_comb begin
      g0_vld   = 1'b0;
      g0_idx   = '0;
      cand_vld = 1'b0;
      cand_idx = '0;
      scan_src = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan_src = (int'(rr_ptr_q) + k) % NUM_SRC;
         if (!fifo_empty[scan_src]) begin
            if (!g0_vld) begin
               g0_vld = 1'b1;
               g0_idx = SW'(scan_src);
            end else if (!cand_vld) begin
               cand_vld = 1'b1;
               cand_idx = SW'(scan_src);
            end
         end
      end

      g1_vld = cand_vld;
      g1_idx = cand_idx;
`ifdef WB_COLLISION_CHK_EN
      // Same destination as port 0: hold the candidate at its head rather than
      // looking further, so it keeps its turn next cycle.
      if (cand_vld && (fifo_head[cand_idx].addr == fifo_head[g0_idx].addr)) begin
         g1_vld = 1'b0;
      end
`endif

      rr_ptr_d = rr_ptr_q;
      if (g1_vld) begin
         rr_ptr_d = SW'(wb_next_src(int'(g1_idx), NUM_SRC));
      end else if (g0_vld) begin
         rr_ptr_d = SW'(wb_next_src(int'(g0_idx), NUM_SRC));
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rr_ptr_q <= '0;
         for (int p = 0; p < NUM_WPORTS; p++) begin
            w_en_q[p]   <= 1'b0;
            w_addr_q[p] <= '0;
            w_data_q[p] <= '0;
         end
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         w_en_q[0] <= g0_vld;
         w_en_q[1] <= g1_vld;
         // Address/data only load on a grant; stale values are don't-care when en is low.
         if (g0_vld) begin
            w_addr_q[0] <= fifo_head[g0_idx].addr;
            w_data_q[0] <= fifo_head[g0_idx].data;
         end
         if (g1_vld) begin
            w_addr_q[1] <= fifo_head[g1_idx].addr;
            w_data_q[1] <= fifo_head[g1_idx].data;
         end
      end
   end

   assign o_w_en   = w_en_q;
   assign o_w_addr = w_addr_q;
   assign o_w_data = w_data_q;

   always_comb begin
      o_idle = !w_en_q[0] && !w_en_q[1];
      for (int s = 0; s < NUM_SRC; s++) begin
         if (!fifo_empty[s]) begin
            o_idle = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int NS = 4;
   localparam int FD = 4;

   logic clk = 1'b0;
   logic rst;
   logic valid  [0:NS-1];
   logic ready  [0:NS-1];
   p_reg addr   [0:NS-1];
   word  data   [0:NS-1];
   logic w_en   [0:1];
   p_reg w_addr [0:1];
   word  w_data [0:1];
   logic idle;

   writeback_arbiter #(
      .NUM_SRC    (NS),
      .FIFO_DEPTH (FD),
      .NUM_WPORTS (2)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid),
      .o_ready  (ready),
      .i_addr   (addr),
      .i_data   (data),
      .o_w_en   (w_en),
      .o_w_addr (w_addr),
      .o_w_data (w_data),
      .o_idle   (idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   cyc;
      p_reg addr;
      word  data;
   } exp_t;

   exp_t      expq [2][$];     // expected writes per port, stamped with their cycle
   wb_entry_t mq   [NS][$];    // reference contents of each source buffer
   int        rr;
   bit        last_any;
   bit        nv   [NS];
   p_reg      na   [NS];
   word       nd   [NS];
   bit        prev_acc [NS];
   int        n_chk  = 0;
   int        n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: consume expected writes whenever the DUT presents one.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         for (int p = 0; p < 2; p++) begin
            if (w_en[p]) begin
               if (expq[p].size() == 0) begin
                  chk($sformatf("p%0d_unexpected_write", p), 64'(w_en[p]), 64'(0));
               end else begin
                  e = expq[p].pop_front();
                  chk($sformatf("p%0d_cycle", p), 64'(cyc), 64'(e.cyc));
                  chk($sformatf("p%0d_addr", p), 64'(w_addr[p]), 64'(e.addr));
                  chk($sformatf("p%0d_data", p), 64'(w_data[p]), 64'(e.data));
               end
            end else if (expq[p].size() > 0 && expq[p][0].cyc <= cyc) begin
               chk($sformatf("p%0d_missing_write", p), 64'(w_en[p]), 64'(1));
               void'(expq[p].pop_front());
            end
         end
      end
   end

   // One clock of stimulus plus the reference model for the coming edge.
   task automatic step();
      int  order[$];
      bit  acc [NS];
      bit  all_empty;
      int  g0, g1, ng;
      @(negedge clk);
      #1;
      all_empty = 1'b1;
      for (int s = 0; s < NS; s++) begin
         chk($sformatf("ready%0d", s), 64'(ready[s]), 64'(mq[s].size() < FD));
         if (mq[s].size() != 0) all_empty = 1'b0;
      end
      chk("idle", 64'(idle), 64'(all_empty && !last_any));

      for (int s = 0; s < NS; s++) begin
         valid[s] = nv[s];
         addr[s]  = na[s];
         data[s]  = nd[s];
         acc[s]   = nv[s] && (mq[s].size() < FD);
      end

      // Non-empty sources in rotation order from rr.
      for (int k = 0; k < NS; k++) begin
         if (mq[(rr + k) % NS].size() != 0) order.push_back((rr + k) % NS);
      end
      ng = 0; g0 = 0; g1 = 0;
      if (order.size() >= 1) begin
         g0 = order[0];
         ng = 1;
      end
      if (order.size() >= 2) begin
`ifdef WB_COLLISION_CHK_EN
         if (mq[order[1]][0].addr != mq[g0][0].addr) begin
            g1 = order[1];
            ng = 2;
         end
`else
         g1 = order[1];
         ng = 2;
`endif
      end
      if (ng >= 1) begin
         expq[0].push_back('{cyc + 1, mq[g0][0].addr, mq[g0][0].data});
         void'(mq[g0].pop_front());
         rr = (g0 + 1) % NS;
      end
      if (ng == 2) begin
         expq[1].push_back('{cyc + 1, mq[g1][0].addr, mq[g1][0].data});
         void'(mq[g1].pop_front());
         rr = (g1 + 1) % NS;
      end
      last_any = (ng > 0);

      for (int s = 0; s < NS; s++) begin
         if (acc[s] && na[s] != 0) mq[s].push_back('{addr: na[s], data: nd[s]});
         prev_acc[s] = acc[s];
      end
   endtask

   task automatic clear_nv();
      for (int s = 0; s < NS; s++) begin
         nv[s] = 1'b0;
         na[s] = '0;
         nd[s] = '0;
      end
   endtask

   task automatic set_src(input int s, input p_reg a, input word d);
      nv[s] = 1'b1;
      na[s] = a;
      nd[s] = d;
   endtask

   task automatic idle_steps(input int n);
      clear_nv();
      repeat (n) step();
   endtask

   // Random traffic; a source left waiting keeps its request stable.
   task automatic random_phase(input int n, input int pct, input int amax);
      repeat (n) begin
         for (int s = 0; s < NS; s++) begin
            if (!(nv[s] && !prev_acc[s])) begin
               nv[s] = ($urandom_range(0, 99) < pct);
               na[s] = p_reg'($urandom_range(0, amax));
               nd[s] = $urandom;
            end
         end
         step();
      end
      clear_nv();
   endtask

   task automatic reset_model();
      for (int s = 0; s < NS; s++) begin
         mq[s].delete();
         prev_acc[s] = 1'b0;
      end
      expq[0].delete();
      expq[1].delete();
      rr = 0;
      last_any = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_nv();
      for (int s = 0; s < NS; s++) begin
         valid[s] = 1'b0;
         addr[s]  = '0;
         data[s]  = '0;
      end
      reset_model();

      repeat (2) @(negedge clk);
      #1;
      chk("rst_wen0", 64'(w_en[0]), 64'(0));
      chk("rst_wen1", 64'(w_en[1]), 64'(0));
      chk("rst_waddr0", 64'(w_addr[0]), 64'(0));
      chk("rst_wdata1", 64'(w_data[1]), 64'(0));
      chk("rst_ready0", 64'(ready[0]), 64'(0));
      chk("rst_idle", 64'(idle), 64'(1));
      rst = 1'b0;

      // Single result, uncontended latency.
      clear_nv();
      set_src(1, 6'd5, 32'hDEADBEEF);
      step();
      idle_steps(4);

      // All four sources at once: two per cycle in rotation order.
      clear_nv();
      for (int s = 0; s < NS; s++) set_src(s, p_reg'(10 + s), 32'h100 + s);
      step();
      idle_steps(4);

      // Register 0 write is swallowed.
      clear_nv();
      set_src(0, 6'd0, 32'h1234);
      step();
      idle_steps(4);

      // Same destination from two sources.
      clear_nv();
      set_src(0, 6'd7, 32'hA);
      set_src(2, 6'd7, 32'hB);
      step();
      idle_steps(4);

      // Saturation drives the buffers full; then mixed and collision-heavy traffic.
      random_phase(60, 100, 63);
      idle_steps(6);
      random_phase(1500, 50, 63);
      random_phase(500, 70, 7);
      idle_steps(6);

      // Reset with three entries still buffered and writes in flight.
      clear_nv();
      for (int s = 0; s < NS; s++) set_src(s, p_reg'(20 + s), 32'h200 + s);
      step();
      clear_nv();
      set_src(0, 6'd24, 32'h204);
      step();
      @(negedge clk);
      #1;
      chk("pre_rst_wen0", 64'(w_en[0]), 64'(1));
      rst = 1'b1;
      for (int s = 0; s < NS; s++) valid[s] = 1'b0;
      clear_nv();
      #1;
      chk("mid_rst_wen0", 64'(w_en[0]), 64'(0));
      chk("mid_rst_wen1", 64'(w_en[1]), 64'(0));
      chk("mid_rst_ready", 64'(ready[1]), 64'(0));
      chk("mid_rst_idle", 64'(idle), 64'(1));
      reset_model();
      @(negedge clk);
      #1;
      rst = 1'b0;
      idle_steps(6);

      random_phase(300, 60, 31);
      idle_steps(10);

      chk("leftover_p0", 64'(expq[0].size()), 64'(0));
      chk("leftover_p1", 64'(expq[1].size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the register file's two write ports.
- Collects results from NUM_SRC functional units, each with a valid/ready handshake. Buffers them in per-source FIFOs.
- Each cycle, round-robin selects up to two entries and drives them as registered write-port signals (o_w_en/o_w_addr/o_w_data) straight into the register file.
- Sits between execute units and the register file at the writeback stage.

Parameters:
- NUM_SRC, 4: number of result producers (2..8).
- FIFO_DEPTH, 4: entries per source FIFO (power of two, >=2).
- NUM_WPORTS, 2: register-file write ports driven. Fixed at 2; included for readability only.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1 [0:NUM_SRC-1]  source s presents a result.
- o_ready  output  1 [0:NUM_SRC-1]  source s FIFO can accept.
- i_addr  input  p_reg [0:NUM_SRC-1]  destination physical register.
- i_data  input  word [0:NUM_SRC-1]  result value.
- o_w_en  output  1 [0:1]  write-port enable.
- o_w_addr  output  p_reg [0:1]  write-port address.
- o_w_data  output  word [0:1]  write-port data.
- o_idle  output  1  all FIFOs empty and both o_w_en low.

Behaviour:
- Reset (async, i_rst high):
  - FIFOs emptied; round-robin pointer rr_ptr=0.
  - o_w_en, o_w_addr, o_w_data all 0.
  - o_ready forced 0 while i_rst is high. o_idle=1.
- Handshake:
  - Transfer on posedge when i_valid[s] && o_ready[s].
  - o_ready[s] = !full[s], computed from registered occupancy only. No push into a full FIFO even if it is popped the same cycle (no comb path from grant to ready).
  - Source must hold i_addr/i_data stable while i_valid is high and ready is low.
- Address 0:
  - Transfer with i_addr==0 completes the handshake but is not enqueued (register 0 is hardwired zero).
- Ordering:
  - Per-source FIFO order preserved.
  - No ordering guarantee across sources.
- Arbitration (combinational on registered FIFO state, each cycle):
  - Port 0 grant: first non-empty source scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
  - Port 1 grant: next non-empty source after the port-0 grant in the same scan order.
  - At most one pop per source per cycle.
  - Granted heads popped at posedge and loaded into the output registers.
  - Ungranted port: o_w_en=0. Addr/data hold their previous values (don't-care).
- rr_ptr update:
  - Becomes (last granted source + 1) mod NUM_SRC when any grant occurs.
  - Unchanged when there is no grant.
- Latency:
  - Handshake at edge k → earliest o_w_en visible after edge k+1 (2 cycles) when uncontended.
- Throughput: 2 writes/cycle sustained when at least 2 sources are non-empty.
- Simultaneous push and pop on the same FIFO: allowed when not full; occupancy unchanged.
- Pointer wrap: FIFO pointers use log2(FIFO_DEPTH)+1 bits; full/empty are distinguished by the MSB.
- Same-address collision: two granted entries with identical addr are both issued (port 1 wins in the register file), unless the optional feature is enabled.
- Reset mid-operation: all buffered entries are discarded and any pending o_w_en drops immediately (async).

Optional Feature:
- Macro: WB_COLLISION_CHK_EN.
- Defined: if the port-1 candidate has the same addr as the port-0 grant, port 1 is not granted that cycle. That entry stays at its FIFO head and the scan does not skip to another source. rr_ptr advances past the port-0 source only. Guarantees no same-cycle duplicate write addresses.
- Undefined: no comparison; duplicate addresses may issue together.

Decomposition:
- Types package (existing): p_reg, word.
- Add to the package: WB_NUM_WPORTS=2 constant and a wb_entry_t struct {p_reg addr; word data}.
- Sub-module: wb_fifo, a parameterised synchronous FIFO of wb_entry_t exposing push, pop, head, empty and full. One instance per source.
- Arbiter and output registers live in the top.

Test Plan:
- Reset then single push (src1, addr 5, data 0xDEADBEEF) → o_w_en[0]=1, addr 5, data 0xDEADBEEF exactly 2 cycles later; o_w_en[1]=0; o_idle returns to 1 the cycle after.
- All 4 sources push one entry in the same cycle (addrs 10..13) → cycle+2: ports carry src0/src1; cycle+3: src2/src3; rr_ptr ends at 0.
- Hold src0 valid continuously, others idle, with the bench stalling by not clocking grants → after 4 accepts o_ready[0]=0. Drain → ready reasserts the cycle after the first pop; data emerges in push order.
- Push addr 0 with data 0x1234 → handshake completes; no o_w_en ever asserted; o_idle stays 1.
- src0 and src2 both push addr 7 (data 0xA / 0xB) → without WB_COLLISION_CHK_EN both ports write addr 7 in the same cycle. With the macro: 0xA on port 0, then 0xB on port 0 the next cycle.
- Assert i_rst mid-stream with 3 entries buffered → o_w_en drops immediately; after release no stale writes appear and o_ready goes to 1.
